// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/funct7/funct3 and executes base RV32I ops in one cycle,
// with an optional iterative RV32M multiply/divide engine behind a valid/ready handshake.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid_in,
  input  logic [1:0]      i_alu_op,
  input  logic [6:0]      i_funct7,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_ready_out,
  output logic            o_valid_out,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic [4:0]      o_ctrl_code,
  output logic            o_illegal,
  output logic            o_busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] C_AND  = 5'h00, C_OR   = 5'h01, C_ADD    = 5'h02, C_XOR   = 5'h03;
  localparam logic [4:0] C_SLL  = 5'h04, C_SRL  = 5'h05, C_SUB    = 5'h06, C_SRA   = 5'h07;
  localparam logic [4:0] C_SLT  = 5'h08, C_SLTU = 5'h09, C_MUL    = 5'h10, C_MULH  = 5'h11;
  localparam logic [4:0] C_MULHSU = 5'h12, C_MULHU = 5'h13, C_DIV = 5'h14, C_DIVU  = 5'h15;
  localparam logic [4:0] C_REM  = 5'h16, C_REMU = 5'h17;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state, w_nextState;
  logic [CW-1:0]     r_count;
  logic [4:0]        r_code;
  logic              r_negHi, r_negLo;
  logic [2*XLEN-1:0] r_mcand, r_acc;
  logic [XLEN-1:0]   r_mplier, r_quo, r_rem, r_divisor;
  logic [XLEN-1:0]   r_result;
  logic              r_zero, r_valid, r_illegal;
  logic [4:0]        r_ctrl;

  logic [4:0]        w_code;
  logic              w_illegal, w_isMd, w_isDiv, w_divZero, w_ovf, w_special;
  logic              w_aSigned, w_bSigned, w_negA, w_negB;
  logic              w_accept, w_startMd, w_geq;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_absA, w_absB, w_baseResult, w_specialRes, w_immResult, w_mdResult;
  logic [XLEN-1:0]   w_quo, w_rem;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN:0]     w_shift;

  // Illegal encodings collapse to ADD so the reported control code is always well defined.
  always_comb begin
    w_code    = C_ADD;
    w_illegal = 1'b0;
    unique case (i_alu_op)
      2'b00: w_code = C_ADD;
      2'b01: w_code = C_SUB;
      2'b10: begin
        if (i_funct7 == 7'b0000000) begin
          unique case (i_funct3)
            3'b000: w_code = C_ADD;
            3'b001: w_code = C_SLL;
            3'b010: w_code = C_SLT;
            3'b011: w_code = C_SLTU;
            3'b100: w_code = C_XOR;
            3'b101: w_code = C_SRL;
            3'b110: w_code = C_OR;
            default: w_code = C_AND;
          endcase
        end else if (i_funct7 == 7'b0100000 && i_funct3 == 3'b000) begin
          w_code = C_SUB;
        end else if (i_funct7 == 7'b0100000 && i_funct3 == 3'b101) begin
          w_code = C_SRA;
        end else if (i_funct7 == 7'b0000001 && ENABLE_M) begin
          w_code = {2'b10, i_funct3};
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: begin
        unique case (i_funct3)
          3'b000: w_code = C_ADD;
          3'b010: w_code = C_SLT;
          3'b011: w_code = C_SLTU;
          3'b100: w_code = C_XOR;
          3'b110: w_code = C_OR;
          3'b111: w_code = C_AND;
          3'b001: begin
            if (i_funct7 == 7'b0000000) w_code = C_SLL;
            else w_illegal = 1'b1;
          end
          default: begin
            if (i_funct7 == 7'b0000000) w_code = C_SRL;
            else if (i_funct7 == 7'b0100000) w_code = C_SRA;
            else w_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    w_aSigned = 1'b0;
    w_bSigned = 1'b0;
    case (w_code)
      C_MUL, C_MULH, C_DIV, C_REM: begin
        w_aSigned = 1'b1;
        w_bSigned = 1'b1;
      end
      C_MULHSU: w_aSigned = 1'b1;
      default: ;
    endcase
  end

  assign w_isMd    = !w_illegal && w_code[4];
  assign w_isDiv   = w_isMd && (w_code[4:2] == 3'b101);
  assign w_divZero = w_isDiv && (i_op_b == '0);
  assign w_ovf     = w_isDiv && !w_code[0] && (i_op_a == MIN_NEG) && (i_op_b == '1);
  assign w_special = w_divZero || w_ovf;
  assign w_negA    = w_aSigned && i_op_a[XLEN-1];
  assign w_negB    = w_bSigned && i_op_b[XLEN-1];
  assign w_absA    = w_negA ? -i_op_a : i_op_a;
  assign w_absB    = w_negB ? -i_op_b : i_op_b;
  assign w_shamt   = i_op_b[SHW-1:0];

  // Divide-by-zero and signed overflow finish immediately with RISC-V defined results.
  always_comb begin
    w_specialRes = '0;
    if (w_divZero) w_specialRes = w_code[1] ? i_op_a : '1;
    else if (w_ovf) w_specialRes = w_code[1] ? '0 : i_op_a;
  end

  always_comb begin
    w_baseResult = '0;
    case (w_code)
      C_AND:  w_baseResult = i_op_a & i_op_b;
      C_OR:   w_baseResult = i_op_a | i_op_b;
      C_ADD:  w_baseResult = i_op_a + i_op_b;
      C_XOR:  w_baseResult = i_op_a ^ i_op_b;
      C_SLL:  w_baseResult = i_op_a << w_shamt;
      C_SRL:  w_baseResult = i_op_a >> w_shamt;
      C_SUB:  w_baseResult = i_op_a - i_op_b;
      C_SRA:  w_baseResult = $unsigned($signed(i_op_a) >>> w_shamt);
      C_SLT:  w_baseResult = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      C_SLTU: w_baseResult = {{(XLEN-1){1'b0}}, (i_op_a < i_op_b)};
      default: w_baseResult = '0;
    endcase
  end

  assign w_immResult = w_illegal ? '0 : (w_special ? w_specialRes : w_baseResult);
  assign w_accept    = i_valid_in && (r_state == S_IDLE);
  assign w_startMd   = w_accept && w_isMd && !w_special;

  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_geq   = w_shift >= {1'b0, r_divisor};
  assign w_prod  = r_negHi ? -r_acc : r_acc;
  assign w_quo   = r_negHi ? -r_quo : r_quo;
  assign w_rem   = r_negLo ? -r_rem : r_rem;

  always_comb begin
    w_mdResult = w_rem;
    case (r_code)
      C_MUL:                    w_mdResult = w_prod[XLEN-1:0];
      C_MULH, C_MULHSU, C_MULHU: w_mdResult = w_prod[2*XLEN-1:XLEN];
      C_DIV, C_DIVU:            w_mdResult = w_quo;
      default:                  w_mdResult = w_rem;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE: if (w_startMd) w_nextState = S_CALC;
      S_CALC: if (r_count == CW'(1)) w_nextState = S_DONE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  // Both iterative datapaths step every CALC cycle; r_code picks which one is reported.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count   <= '0;
      r_code    <= '0;
      r_negHi   <= 1'b0;
      r_negLo   <= 1'b0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplier  <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_ctrl    <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_startMd) begin
            r_count   <= CNT_INIT;
            r_code    <= w_code;
            r_negHi   <= w_negA ^ w_negB;
            r_negLo   <= w_negA;
            r_mcand   <= {{XLEN{1'b0}}, w_absA};
            r_acc     <= '0;
            r_mplier  <= w_absB;
            r_quo     <= w_absA;
            r_rem     <= '0;
            r_divisor <= w_absB;
          end else if (w_accept) begin
            r_result  <= w_immResult;
            r_zero    <= (w_immResult == '0);
            r_ctrl    <= w_code;
            r_illegal <= w_illegal;
            r_valid   <= 1'b1;
          end
        end
        S_CALC: begin
          r_count  <= r_count - CW'(1);
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_rem    <= w_geq ? (w_shift[XLEN-1:0] - r_divisor) : w_shift[XLEN-1:0];
          r_quo    <= {r_quo[XLEN-2:0], w_geq};
        end
        default: begin
          r_result  <= w_mdResult;
          r_zero    <= (w_mdResult == '0);
          r_ctrl    <= r_code;
          r_illegal <= 1'b0;
          r_valid   <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready_out = (r_state == S_IDLE);
  assign o_busy      = (r_state == S_CALC);
  assign o_valid_out = r_valid;
  assign o_result    = r_result;
  assign o_zero      = r_zero;
  assign o_ctrl_code = r_ctrl;
  assign o_illegal   = r_illegal;

endmodule
